wbs_mem: RTL and testbench

- Wishbone classic (B3, non-pipelined) slave memory: the responder end of the bus driven by the fetch and load/store stages.
- Word-organised synchronous RAM with:
  - byte-lane writes
  - registered ack/err
  - range and alignment checking
- Sits behind the bus as instruction/data memory for simulation and FPGA builds.

---
 rtl/wbs_mem.sv | 220 ++++++++++++++++++++++
 tb/tb_wbs_mem.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_mem.sv
// -----------------------------------------------------------------------------
// wbs_mem
// Wishbone B3 classic (non-pipelined) slave memory. This is a word-organised
// synchronous RAM with byte-lane writes, registered ack/err, and range and
// alignment checking on every request.
//
// Parameters
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   DEPTH        number of 32-bit words (power of two)
//   WAIT_CYCLES  wait states before ack/err (0..255, wait build only)
//
// Build option
//   WBS_MEM_WAIT_EN  when defined, the WAIT state and its 8-bit counter exist
//                    and WAIT_CYCLES wait states are inserted. When undefined,
//                    the latency is fixed at one cycle.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   wbs_addr_i  byte address
//   wbs_dat_i   write data
//   wbs_sel_i   byte lane select (read with sel=0 means full word)
//   wbs_cyc_i   bus cycle valid (qualifies stb)
//   wbs_stb_i   strobe
//   wbs_we_i    1 = write, 0 = read
//   wbs_dat_o   read data; holds until the next successful read
//   wbs_ack_o   transfer acknowledge (one cycle)
//   wbs_err_o   transfer error (one cycle)
// -----------------------------------------------------------------------------
module wbs_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if ((DEPTH < 2) || (DEPTH > (1 << 29)) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (BASE_ADDR[1:0] != 2'b00) || (WAIT_CYCLES > 255)) begin : g_param_check
        $error("wbs_mem: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;

    logic [31:0] mem [DEPTH];

    logic [31:0] off;
    logic [3:0]  eff_sel;
    logic        lane_err;
    logic        range_err;
    logic        req;

    logic [31:0] dat_q;
    logic        ack_q;
    logic        err_q;

    // Commit port: the transfer that enters RESP at the coming edge.
    logic          cm_go;
    logic          cm_we;
    logic          cm_err;
    logic [AW-1:0] cm_idx;
    logic [31:0]   cm_dat;
    logic [3:0]    cm_sel;

`ifdef WBS_MEM_WAIT_EN
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

    logic [7:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          rerr_q;
`endif

    assign req = wbs_cyc_i && wbs_stb_i;
    assign off = wbs_addr_i - BASE_ADDR;

    // Any offset bit above the word index means the address is out of range
    // (this also catches addresses below BASE_ADDR, which wrap to large values).
    assign range_err = |off[31:AW+2];

    always_comb begin
        // The fetch stage drives sel=0 on reads; that means a full word.
        eff_sel = (!wbs_we_i && (wbs_sel_i == 4'b0000)) ? 4'b1111 : wbs_sel_i;
        case (eff_sel)
            4'b0000:                            lane_err = 1'b0;
            4'b1111:                            lane_err = (off[1:0] != 2'b00);
            4'b0011, 4'b1100:                   lane_err = off[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: lane_err = 1'b0;
            default:                            lane_err = 1'b1;
        endcase
    end

    always_comb begin
        cm_go  = 1'b0;
        cm_we  = wbs_we_i;
        cm_err = range_err || lane_err;
        cm_idx = off[AW+1:2];
        cm_dat = wbs_dat_i;
        cm_sel = eff_sel;
`ifdef WBS_MEM_WAIT_EN
        if ((state == S_IDLE) && req && (WAIT_LD == 8'd0)) begin
            cm_go = 1'b1;
        end
        if ((state == S_WAIT) && wbs_cyc_i && (cnt_q == 8'd0)) begin
            cm_go  = 1'b1;
            cm_we  = we_q;
            cm_err = rerr_q;
            cm_idx = idx_q;
            cm_dat = wdat_q;
            cm_sel = sel_q;
        end
`else
        if ((state == S_IDLE) && req) begin
            cm_go = 1'b1;
        end
`endif
    end

    // Memory is not reset. The rst_ni gate keeps a request presented during
    // reset from writing.
    always_ff @(posedge clk_i) begin
        if (rst_ni && cm_go && cm_we && !cm_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (cm_sel[b]) begin
                    mem[cm_idx][8*b +: 8] <= cm_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= S_IDLE;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
`ifdef WBS_MEM_WAIT_EN
            cnt_q  <= '0;
            idx_q  <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            rerr_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
`ifdef WBS_MEM_WAIT_EN
                        idx_q  <= off[AW+1:2];
                        wdat_q <= wbs_dat_i;
                        sel_q  <= eff_sel;
                        we_q   <= wbs_we_i;
                        rerr_q <= range_err || lane_err;
                        if (WAIT_LD != 8'd0) begin
                            cnt_q <= WAIT_LD - 8'd1;
                            state <= S_WAIT;
                        end else begin
                            state <= S_RESP;
                        end
`else
                        state <= S_RESP;
`endif
                    end
                end
`ifdef WBS_MEM_WAIT_EN
                S_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt_q == 8'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
`endif
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (cm_go) begin
                if (cm_err) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    if (!cm_we) begin
                        dat_q <= mem[cm_idx];
                    end
                end
            end
        end
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wbs_mem.sv
// -----------------------------------------------------------------------------
// tb_wbs_mem
// Directed self-checking bench for wbs_mem. It checks the reset state,
// full-word and byte-lane accesses, error responses, back-to-back ack spacing,
// wait states and abort (WBS_MEM_WAIT_EN build), and reset in the middle of a
// transfer.
// -----------------------------------------------------------------------------
module tb_wbs_mem;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DEPTH = 256;
`ifdef WBS_MEM_WAIT_EN
    localparam int unsigned WAITS = 3;
`else
    localparam int unsigned WAITS = 0;
`endif
    localparam int LAT = 1 + int'(WAITS);

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] wbs_addr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    int checks = 0;
    int errors = 0;

    wbs_mem #(
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wbs_addr_i(wbs_addr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic we);
        wbs_addr_i = a;
        wbs_dat_i  = d;
        wbs_sel_i  = s;
        wbs_we_i   = we;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
    endtask

    task automatic idle_bus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'b0000;
    endtask

    // Runs one transfer and reports what the bus showed. The caller does the
    // checking. lat is -1 if no response arrived within the cycle budget.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic we,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] rdata, output logic resp_after);
        lat = -1;
        ack = 1'b0;
        err = 1'b0;
        rdata = '0;
        drive(a, d, s, we);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #1;
            if (wbs_ack_o || wbs_err_o) begin
                lat   = k;
                ack   = wbs_ack_o;
                err   = wbs_err_o;
                rdata = wbs_dat_o;
                break;
            end
        end
        idle_bus();
        @(posedge clk_i);
        #1;
        resp_after = wbs_ack_o || wbs_err_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_bus();
        wbs_addr_i = '0;
        wbs_dat_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", wbs_ack_o); end
        checks++; if (wbs_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", wbs_err_o); end
        checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 00000000", wbs_dat_o); end
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_write_read();
        int lat; logic ack, err, after; logic [31:0] rd;
        xfer(BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b1, lat, ack, err, rd, after);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL wr_lat got %0d exp %0d", lat, LAT); end
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL wr_ackerr got %b%b exp 10", ack, err); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL wr_single_ack got %b exp 0", after); end
        xfer(BASE + 32'h10, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rd_lat got %0d exp %0d", lat, LAT); end
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL rd_ackerr got %b%b exp 10", ack, err); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic ack, err, after; logic [31:0] rd;
        xfer(BASE + 32'h10, 32'h0000_00AA, 4'b0001, 1'b1, lat, ack, err, rd, after);
        xfer(BASE + 32'h10, 32'h0, 4'b1111, 1'b0, lat, ack, err, rd, after);
        checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL lane0 got %h exp deadbeaa", rd); end
        xfer(BASE + 32'h12, 32'h1234_5678, 4'b1100, 1'b1, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL half_hi_ack got %b%b exp 10", ack, err); end
        xfer(BASE + 32'h10, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (rd !== 32'h1234_BEAA) begin errors++; $display("FAIL half_hi got %h exp 1234beaa", rd); end
        xfer(BASE + 32'h13, 32'h0056_0000, 4'b0100, 1'b1, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL byte_odd_ack got %b%b exp 10", ack, err); end
        xfer(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b1, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL noop_ack got %b%b exp 10", ack, err); end
        xfer(BASE + 32'h10, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (rd !== 32'h1256_BEAA) begin errors++; $display("FAIL byte_noop got %h exp 1256beaa", rd); end
    endtask

    task automatic test_errors();
        int lat; logic ack, err, after; logic [31:0] rd;
        // dat_o currently holds 1256BEAA from the last read.
        xfer(BASE + 32'(4 * DEPTH), 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL oor_lat got %0d exp %0d", lat, LAT); end
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL oor_ackerr got %b%b exp 01", ack, err); end
        checks++; if (rd !== 32'h1256_BEAA) begin errors++; $display("FAIL oor_dat got %h exp 1256beaa", rd); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL oor_single got %b exp 0", after); end
        xfer(BASE + 32'h11, 32'h0BAD_0BAD, 4'b1111, 1'b1, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL misalign_ackerr got %b%b exp 01", ack, err); end
        xfer(BASE + 32'h11, 32'h0BAD_0BAD, 4'b0011, 1'b1, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL half_odd_ackerr got %b%b exp 01", ack, err); end
        xfer(BASE + 32'h10, 32'h0BAD_0BAD, 4'b0101, 1'b1, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL sel0101_ackerr got %b%b exp 01", ack, err); end
        xfer(BASE - 32'h4, 32'h0, 4'b1111, 1'b0, lat, ack, err, rd, after);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL below_base_ackerr got %b%b exp 01", ack, err); end
        xfer(BASE + 32'h10, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (rd !== 32'h1256_BEAA) begin errors++; $display("FAIL err_mem got %h exp 1256beaa", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic ack, err, after; logic [31:0] rd;
        logic [31:0] exp_w [3];
        int n;
        bit exp_ack, prev_ack;
        exp_w[0] = 32'h1111_1111;
        exp_w[1] = 32'h2222_2222;
        exp_w[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            xfer(BASE + 32'(4 * i), exp_w[i], 4'b1111, 1'b1, lat, ack, err, rd, after);
        end
        n = 0;
        prev_ack = 1'b0;
        drive(BASE, 32'h0, 4'b0000, 1'b0);
        for (int c = 1; c <= 3 * LAT + 4; c++) begin
            @(posedge clk_i);
            #1;
            exp_ack = (c == LAT) || (c == 2 * LAT + 1) || (c == 3 * LAT + 2);
            checks++; if (wbs_ack_o !== exp_ack) begin errors++; $display("FAIL b2b_ack cycle %0d got %b exp %b", c, wbs_ack_o, exp_ack); end
            checks++; if (prev_ack && wbs_ack_o) begin errors++; $display("FAIL b2b_spacing cycle %0d got ack after ack exp gap", c); end
            prev_ack = wbs_ack_o;
            if (wbs_ack_o && n < 3) begin
                checks++; if (wbs_dat_o !== exp_w[n]) begin errors++; $display("FAIL b2b_data word %0d got %h exp %h", n, wbs_dat_o, exp_w[n]); end
                n++;
                if (n < 3) wbs_addr_i = BASE + 32'(4 * n);
                else idle_bus();
            end
        end
        idle_bus();
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
    endtask

`ifdef WBS_MEM_WAIT_EN
    task automatic test_wait();
        int lat; logic ack, err, after; logic [31:0] rd;
        xfer(BASE, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait_lat got %0d exp 4", lat); end
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL wait_data got %h exp 11111111", rd); end
        drive(BASE + 32'h4, 32'h9999_9999, 4'b1111, 1'b1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        idle_bus();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            checks++; if ({wbs_ack_o, wbs_err_o} !== 2'b00) begin errors++; $display("FAIL abort_resp cycle %0d got %b%b exp 00", c, wbs_ack_o, wbs_err_o); end
        end
        xfer(BASE + 32'h4, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL abort_mem got %h exp 22222222", rd); end
    endtask
`endif

    task automatic test_reset_mid();
        int lat; logic ack, err, after; logic [31:0] rd;
        xfer(BASE + 32'h8, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
`ifdef WBS_MEM_WAIT_EN
        // Write to word 2, then pulse reset while the write is in WAIT.
        drive(BASE + 32'h8, 32'hAAAA_AAAA, 4'b1111, 1'b1);
        @(posedge clk_i); #1;
        checks++; if (wbs_dat_o !== 32'h3333_3333) begin errors++; $display("FAIL rstmid_pre_dat got %h exp 33333333", wbs_dat_o); end
`else
        // Read word 2 and pulse reset during its ack cycle, then present a
        // write while reset is held.
        drive(BASE + 32'h8, 32'h0, 4'b0000, 1'b0);
        @(posedge clk_i); #1;
        checks++; if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'h3333_3333}) begin errors++; $display("FAIL rstmid_pre got ack %b dat %h exp ack 1 dat 33333333", wbs_ack_o, wbs_dat_o); end
        wbs_dat_i = 32'hAAAA_AAAA;
        wbs_sel_i = 4'b1111;
        wbs_we_i  = 1'b1;
`endif
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({wbs_ack_o, wbs_err_o} !== 2'b00) begin errors++; $display("FAIL rstmid_ackerr got %b%b exp 00", wbs_ack_o, wbs_err_o); end
        checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rstmid_dat got %h exp 00000000", wbs_dat_o); end
        @(posedge clk_i); #1;
        idle_bus();
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        xfer(BASE + 32'h8, 32'h0, 4'b0000, 1'b0, lat, ack, err, rd, after);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rstmid_idle_lat got %0d exp %0d", lat, LAT); end
        checks++; if (rd !== 32'h3333_3333) begin errors++; $display("FAIL rstmid_mem got %h exp 33333333", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
`ifdef WBS_MEM_WAIT_EN
        test_wait();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
